// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core widths and operand types
package core_pkg;

    localparam int CORE_WIDTH = 32;
    localparam int CORE_ROB_W = 3;

    typedef logic [CORE_ROB_W-1:0] rob_tag_t;

    typedef struct packed {
        logic [CORE_WIDTH-1:0] value;
        logic                  ready;
        rob_tag_t              tag;
    } operand_t;

    // True when a broadcast port is active and carries the tag being waited on
    function automatic logic tag_hit(input logic valid, input rob_tag_t a, input rob_tag_t b);
        return valid && (a == b);
    endfunction

endpackage

// File: rtl/operand_resolve.sv
// rtl/operand_resolve.sv - single-operand value resolver (regfile, ROB, commit, CDB)
module operand_resolve
    import core_pkg::*;
#(
    parameter int WIDTH = CORE_WIDTH,
    parameter int ROB_W = CORE_ROB_W
) (
    input  logic             busy,
    input  logic [WIDTH-1:0] reg_value,
    input  logic             rob_value_valid,
    input  logic [WIDTH-1:0] rob_value,
    input  logic [ROB_W-1:0] src_rob,
    input  logic             commit_valid,
    input  logic [ROB_W-1:0] commit_rob,
    input  logic [WIDTH-1:0] commit_value,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_rob,
    input  logic [WIDTH-1:0] cdb_value,
    output logic [WIDTH-1:0] value,
    output logic             ready
);

    logic commit_hit;
    logic cdb_hit;

    assign commit_hit = commit_valid && (commit_rob == src_rob);
    assign cdb_hit    = cdb_valid && (cdb_rob == src_rob);

    // First source that can supply a final value wins; commit outranks CDB
    always_comb begin
        value = '0;
        ready = 1'b0;
        if (!busy) begin
            value = reg_value;
            ready = 1'b1;
        end else if (rob_value_valid) begin
            value = rob_value;
            ready = 1'b1;
        end else if (commit_hit) begin
            value = commit_value;
            ready = 1'b1;
        end else if (cdb_hit) begin
            value = cdb_value;
            ready = 1'b1;
        end
    end

endmodule

// File: rtl/operand_capture_stage.sv
// rtl/operand_capture_stage.sv - registered operand capture with stall-time wakeup
module operand_capture_stage
    import core_pkg::*;
#(
    parameter int WIDTH = CORE_WIDTH,
    parameter int ROB_W = CORE_ROB_W,
    parameter int NSRC  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  is_jal,
    input  logic                  use_imm,
    input  logic                  branch,
    input  logic [WIDTH-1:0]      imm_ext,
    input  logic [NSRC*WIDTH-1:0] reg_value,
    input  logic [NSRC-1:0]       busy,
    input  logic [NSRC*ROB_W-1:0] src_rob,
    input  logic [NSRC*WIDTH-1:0] rob_value,
    input  logic [NSRC-1:0]       rob_value_valid,
    input  logic                  commit_valid,
    input  logic [ROB_W-1:0]      commit_rob,
    input  logic [WIDTH-1:0]      commit_value,
    input  logic                  cdb_valid,
    input  logic [ROB_W-1:0]      cdb_rob,
    input  logic [WIDTH-1:0]      cdb_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NSRC*WIDTH-1:0] op_value,
    output logic [NSRC-1:0]       op_ready,
    output logic [NSRC*ROB_W-1:0] op_rob
);

    typedef struct packed {
        logic [WIDTH-1:0] value;
        logic             ready;
        logic [ROB_W-1:0] tag;
    } slot_t;

    slot_t            op_q [NSRC];
    slot_t            op_d [NSRC];
    logic             out_valid_q;
    logic             out_valid_d;

    logic [WIDTH-1:0] ld_value [NSRC];
    logic             ld_ready [NSRC];
    logic [WIDTH-1:0] wk_value [NSRC];
    logic             wk_ready [NSRC];

    logic             load;
    logic             stall;
    logic             imm_sel;

    assign in_ready = !out_valid_q || out_ready;
    assign load     = in_valid && in_ready;
    assign stall    = out_valid_q && !out_ready;
    assign imm_sel  = use_imm && !branch;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [WIDTH-1:0] raw_value;
        logic             raw_ready;

        operand_resolve #(
            .WIDTH (WIDTH),
            .ROB_W (ROB_W)
        ) u_load_resolve (
            .busy            (busy[i]),
            .reg_value       (reg_value[i*WIDTH +: WIDTH]),
            .rob_value_valid (rob_value_valid[i]),
            .rob_value       (rob_value[i*WIDTH +: WIDTH]),
            .src_rob         (src_rob[i*ROB_W +: ROB_W]),
            .commit_valid    (commit_valid),
            .commit_rob      (commit_rob),
            .commit_value    (commit_value),
            .cdb_valid       (cdb_valid),
            .cdb_rob         (cdb_rob),
            .cdb_value       (cdb_value),
            .value           (raw_value),
            .ready           (raw_ready)
        );

        // A held operand can only be woken by commit or CDB, never by regfile/ROB
        operand_resolve #(
            .WIDTH (WIDTH),
            .ROB_W (ROB_W)
        ) u_wake_resolve (
            .busy            (1'b1),
            .reg_value       ('0),
            .rob_value_valid (1'b0),
            .rob_value       ('0),
            .src_rob         (op_q[i].tag),
            .commit_valid    (commit_valid),
            .commit_rob      (commit_rob),
            .commit_value    (commit_value),
            .cdb_valid       (cdb_valid),
            .cdb_rob         (cdb_rob),
            .cdb_value       (cdb_value),
            .value           (wk_value[i]),
            .ready           (wk_ready[i])
        );

        if (i == 0) begin : g_rs1
            assign ld_value[i] = is_jal ? '0 : raw_value;
            assign ld_ready[i] = is_jal || raw_ready;
        end else if (i == 1) begin : g_rs2
            assign ld_value[i] = imm_sel ? imm_ext : raw_value;
            assign ld_ready[i] = imm_sel || raw_ready;
        end else begin : g_rsn
            assign ld_value[i] = raw_value;
            assign ld_ready[i] = raw_ready;
        end

        assign op_value[i*WIDTH +: WIDTH] = op_q[i].value;
        assign op_ready[i]                = op_q[i].ready;
        assign op_rob[i*ROB_W +: ROB_W]   = op_q[i].tag;
    end

    assign out_valid = out_valid_q;

    // Next state: flush beats load, load beats wakeup, a departing entry just drops valid
    always_comb begin
        out_valid_d = out_valid_q;
        for (int i = 0; i < NSRC; i++) begin
            op_d[i] = op_q[i];
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
            for (int i = 0; i < NSRC; i++) begin
                op_d[i].value = ld_value[i];
                op_d[i].ready = ld_ready[i];
                op_d[i].tag   = src_rob[i*ROB_W +: ROB_W];
            end
        end else if (stall) begin
            for (int i = 0; i < NSRC; i++) begin
                if (!op_q[i].ready && wk_ready[i]) begin
                    op_d[i].value = wk_value[i];
                    op_d[i].ready = 1'b1;
                end
            end
        end else if (out_valid_q) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            for (int i = 0; i < NSRC; i++) begin
                op_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            for (int i = 0; i < NSRC; i++) begin
                op_q[i] <= op_d[i];
            end
        end
    end

endmodule

// File: tb/tb_operand_capture_stage.sv
// tb/tb_operand_capture_stage.sv - self-checking bench for operand_capture_stage
module tb_operand_capture_stage;

    localparam int W  = 32;
    localparam int RW = 3;
    localparam int N  = 2;

    logic            clk;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic            is_jal;
    logic            use_imm;
    logic            branch;
    logic [W-1:0]    imm_ext;
    logic [N*W-1:0]  reg_value;
    logic [N-1:0]    busy;
    logic [N*RW-1:0] src_rob;
    logic [N*W-1:0]  rob_value;
    logic [N-1:0]    rob_value_valid;
    logic            commit_valid;
    logic [RW-1:0]   commit_rob;
    logic [W-1:0]    commit_value;
    logic            cdb_valid;
    logic [RW-1:0]   cdb_rob;
    logic [W-1:0]    cdb_value;
    logic            out_valid;
    logic            out_ready;
    logic [N*W-1:0]  op_value;
    logic [N-1:0]    op_ready;
    logic [N*RW-1:0] op_rob;

    int n_vec  = 0;
    int n_fail = 0;

    operand_capture_stage #(
        .WIDTH (W),
        .ROB_W (RW),
        .NSRC  (N)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .is_jal          (is_jal),
        .use_imm         (use_imm),
        .branch          (branch),
        .imm_ext         (imm_ext),
        .reg_value       (reg_value),
        .busy            (busy),
        .src_rob         (src_rob),
        .rob_value       (rob_value),
        .rob_value_valid (rob_value_valid),
        .commit_valid    (commit_valid),
        .commit_rob      (commit_rob),
        .commit_value    (commit_value),
        .cdb_valid       (cdb_valid),
        .cdb_rob         (cdb_rob),
        .cdb_value       (cdb_value),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .op_value        (op_value),
        .op_ready        (op_ready),
        .op_rob          (op_rob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the instruction currently held at the stage output
    logic         m_valid = 1'b0;
    logic [W-1:0] m_val [N];
    logic         m_rdy [N];
    logic [RW-1:0] m_tag [N];

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_val[i] = '0;
                m_rdy[i] = 1'b0;
                m_tag[i] = '0;
            end
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid = 1'b1;
            for (int i = 0; i < N; i++) begin
                m_tag[i] = src_rob[i*RW +: RW];
                m_rdy[i] = 1'b1;
                if (i == 0 && is_jal)                    m_val[i] = '0;
                else if (i == 1 && use_imm && !branch)   m_val[i] = imm_ext;
                else if (!busy[i])                       m_val[i] = reg_value[i*W +: W];
                else if (rob_value_valid[i])             m_val[i] = rob_value[i*W +: W];
                else if (commit_valid && commit_rob == m_tag[i]) m_val[i] = commit_value;
                else if (cdb_valid && cdb_rob == m_tag[i])       m_val[i] = cdb_value;
                else begin
                    m_val[i] = '0;
                    m_rdy[i] = 1'b0;
                end
            end
        end else if (m_valid && !out_ready) begin
            for (int i = 0; i < N; i++) begin
                if (!m_rdy[i]) begin
                    if (commit_valid && commit_rob == m_tag[i]) begin
                        m_val[i] = commit_value;
                        m_rdy[i] = 1'b1;
                    end else if (cdb_valid && cdb_rob == m_tag[i]) begin
                        m_val[i] = cdb_value;
                        m_rdy[i] = 1'b1;
                    end
                end
            end
        end else begin
            m_valid = 1'b0;
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            for (int i = 0; i < N; i++) begin
                chk("m_op_ready", 64'(op_ready[i]), 64'(m_rdy[i]));
                chk("m_op_rob", 64'(op_rob[i*RW +: RW]), 64'(m_tag[i]));
                chk("m_op_value", 64'(op_value[i*W +: W]), 64'(m_val[i]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; is_jal = 0; use_imm = 0; branch = 0; imm_ext = '0;
        reg_value = '0; busy = '0; src_rob = '0; rob_value = '0; rob_value_valid = '0;
        commit_valid = 0; commit_rob = '0; commit_value = '0;
        cdb_valid = 0; cdb_rob = '0; cdb_value = '0; out_ready = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        reset = 0;
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_op_ready", 64'(op_ready), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        #1; in_valid = 1; out_ready = 1; busy = 2'b00; reg_value = {32'h22, 32'h11};
        step();
        chk("reg_valid", 64'(out_valid), 64'd1);
        chk("reg_value", 64'(op_value), {32'h22, 32'h11});
        chk("reg_ready", 64'(op_ready), 64'b11);

        #1; busy = 2'b11; src_rob = {3'd5, 3'd3};
        commit_valid = 1; commit_rob = 3'd5; commit_value = 32'hAB;
        step();
        chk("commit_ready", 64'(op_ready), 64'b10);
        chk("commit_value", 64'(op_value), {32'hAB, 32'h0});
        chk("commit_rob", 64'(op_rob), 64'b101_011);

        #1; in_valid = 0; out_ready = 0; commit_valid = 0;
        step();
        chk("hold_ready", 64'(op_ready), 64'b10);

        #1; cdb_valid = 1; cdb_rob = 3'd3; cdb_value = 32'h77;
        step();
        chk("wake_ready", 64'(op_ready), 64'b11);
        chk("wake_value", 64'(op_value), {32'hAB, 32'h77});

        #1; cdb_valid = 0; in_valid = 1; out_ready = 1;
        is_jal = 1; use_imm = 1; branch = 0; imm_ext = 32'h800; busy = 2'b11;
        step();
        chk("jal_imm_value", 64'(op_value), {32'h800, 32'h0});
        chk("jal_imm_ready", 64'(op_ready), 64'b11);

        #1; branch = 1; busy = 2'b01; reg_value = {32'h9, 32'h11};
        step();
        chk("branch_value", 64'(op_value), {32'h9, 32'h0});
        chk("branch_ready", 64'(op_ready), 64'b11);

        #1; in_valid = 0; out_ready = 0; is_jal = 0; use_imm = 0; branch = 0;
        step();
        chk("stall_valid", 64'(out_valid), 64'd1);

        #1; flush = 1; in_valid = 1; busy = 2'b00; reg_value = {32'h33, 32'h44};
        step();
        chk("flush_stall", 64'(out_valid), 64'd0);

        #1; flush = 0; out_ready = 1;
        step();
        chk("reload_value", 64'(op_value), {32'h33, 32'h44});

        #1; flush = 1; reg_value = {32'h55, 32'h66};
        step();
        chk("flush_load", 64'(out_valid), 64'd0);

        #1; flush = 0; in_valid = 0;
        step();

        #1; in_valid = 1; out_ready = 1; busy = 2'b11; rob_value_valid = 2'b01;
        rob_value = {32'hBB, 32'hAA}; src_rob = {3'd4, 3'd6};
        cdb_valid = 1; cdb_rob = 3'd4; cdb_value = 32'hCC;
        commit_valid = 1; commit_rob = 3'd4; commit_value = 32'hCC;
        step();
        chk("rob_commit_value", 64'(op_value), {32'hCC, 32'hAA});

        #1; rob_value_valid = 2'b00; commit_valid = 0; cdb_valid = 0; src_rob = {3'd2, 3'd1};
        step();
        chk("wait_ready", 64'(op_ready), 64'b00);

        #1; src_rob = {3'd7, 3'd6}; cdb_valid = 1; cdb_rob = 3'd1; cdb_value = 32'hDD;
        step();
        chk("accept_drop_ready", 64'(op_ready), 64'b00);
        chk("accept_drop_rob", 64'(op_rob), 64'b111_110);

        #1; in_valid = 0; out_ready = 0; cdb_rob = 3'd7; cdb_value = 32'hEE;
        commit_valid = 1; commit_rob = 3'd6; commit_value = 32'hFF;
        step();
        chk("dual_wake_value", 64'(op_value), {32'hEE, 32'hFF});

        #1; reset = 1; commit_valid = 0; cdb_valid = 0;
        step();
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_value", 64'(op_value), 64'd0);

        #1; reset = 0;
        for (int k = 0; k < 32; k++) begin
            in_valid        = (k % 4) != 3;
            out_ready       = (k % 3) != 0;
            flush           = (k % 11) == 10;
            busy            = 2'(k * 3);
            rob_value_valid = 2'(k >> 2);
            src_rob         = 6'(k * 5 + 1);
            reg_value       = {32'(k * 16'h101), 32'(k * 16'h11)};
            rob_value       = {32'(k + 32'h1000), 32'(k + 32'h2000)};
            is_jal          = (k % 7) == 0;
            use_imm         = (k % 5) == 1;
            branch          = (k % 10) == 6;
            imm_ext         = 32'(k * 8);
            commit_valid    = k[0];
            commit_rob      = 3'(k);
            commit_value    = 32'(k + 32'h300);
            cdb_valid       = k[1];
            cdb_rob         = 3'(k + 2);
            cdb_value       = 32'(k + 32'h400);
            step();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
